ili_spi_responder: RTL and testbench
====================================

ILI_SPI_RESPONDER -- requirements
Module: ili_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flops in each input synchronizer chain (min 2).
REQ-002 SHALL have parameter IDLE_MISO, default 1'b1, meaning the o_miso level while deselected.
REQ-003 clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_sclk  input  1  SPI serial clock from the master (mode 0, idle low), asynchronous to clk.
REQ-006 i_mosi  input  1  serial data from the master, MSB first.
REQ-007 i_cs  input  1  chip select, active low.
REQ-008 i_dc  input  1  data/command flag from the master (0 = command, 1 = parameter/data).
REQ-009 i_tx_byte  input  8  byte returned on MISO during the next byte slot.
REQ-010 i_rd_ready  input  1  consumer ready for o_byte.
REQ-011 o_miso  output  1  serial data to the master, MSB first.
REQ-012 o_byte  output  8  last received byte.
REQ-013 o_byte_dc  output  1  i_dc captured at that byte's 8th sclk rising edge.
REQ-014 o_byte_valid  output  1  o_byte/o_byte_dc hold an unconsumed byte.
REQ-015 o_overrun  output  1  sticky: a byte completed while o_byte_valid was high and i_rd_ready was low.
REQ-016 o_frame_active  output  1  synchronized chip select asserted.

Function
REQ-017 i_sclk, i_mosi, i_cs, i_dc SHALL each pass through a SYNC_STAGES-deep synchronizer before any use; the supported sclk high and low times are each >= 3 clk periods.
REQ-018 An sclk rise/fall SHALL be a synchronized 0->1 / 1->0 transition, detected with one additional delay flop.
REQ-019 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-020 IDLE -> SHIFT when synchronized cs goes low; bit counter := 0; tx shift register := i_tx_byte; o_miso := i_tx_byte[7].
REQ-021 In SHIFT, each sclk rise SHALL shift synced mosi into rx shift register LSB and increment the 3-bit bit counter.
REQ-022 On the rise at which the counter wraps 7->0, SHIFT -> DONE, capturing the full byte and synced dc.
REQ-023 DONE SHALL last exactly one clk: if o_byte_valid is low or i_rd_ready is high, load o_byte/o_byte_dc and set o_byte_valid; otherwise keep the old byte and set o_overrun; then -> SHIFT.
REQ-024 Each sclk fall in SHIFT SHALL shift the tx register left and drive its new MSB onto o_miso; after the 8th bit the tx register SHALL reload from i_tx_byte so back-to-back bytes need no gap.
REQ-025 o_byte_valid SHALL clear on a clk where o_byte_valid and i_rd_ready are both high and DONE is not loading; a simultaneous load SHALL keep it high with the new byte.
REQ-026 Synchronized cs going high in any state SHALL -> IDLE, discard a partial byte (no valid, no overrun), set o_miso := IDLE_MISO; a byte already in DONE SHALL complete first.
REQ-027 o_frame_active SHALL equal the inverse of synchronized cs.
REQ-028 o_overrun SHALL clear only on rst.
REQ-029 Latency: o_byte_valid SHALL rise 2 clk after the 8th synchronized sclk rise is detected.

Reset
REQ-030 On rst: FSM = IDLE, counters and shift registers = 0, o_byte = 8'h00, o_byte_dc = 0, o_byte_valid = 0, o_overrun = 0, o_frame_active = 0, o_miso = IDLE_MISO, synchronizer chains preset to the idle bus levels (sclk 0, cs 1, mosi 0, dc 0).
REQ-031 Assertion mid-byte SHALL drop the partial byte; after release the block SHALL wait for a fresh cs falling edge before shifting.

Structure
REQ-032 The FSM state enum (IDLE, SHIFT, DONE) and a byte record typedef {dc, data[7:0]} SHALL live in pkg_ili9341.
REQ-033 One sub-module, spi_sync, SHALL implement a parameterized synchronizer with rise/fall pulse outputs; it SHALL be instantiated once per input pin.

Verification
REQ-034 cs low, dc=0, send 8'h2A at sclk = clk/8 -> one o_byte_valid with o_byte=8'h2A, o_byte_dc=0, o_overrun=0.
REQ-035 i_rd_ready=1, back-to-back 8'h2C (dc=0) then 8'hF8 (dc=1) in one frame -> two valid bytes in order, dc flags 0 then 1.
REQ-036 i_tx_byte=8'hA5 during a frame -> MISO sampled by the bench on sclk rises reads 8'hA5; o_miso=IDLE_MISO after cs high.
REQ-037 i_rd_ready=0, send 8'h01 then 8'h02 -> o_byte stays 8'h01, o_overrun=1 and remains set after i_rd_ready=1.
REQ-038 cs raised after 5 bits of 8'hFF, then 8'h11 sent -> only 8'h11 delivered, no overrun.
REQ-039 rst pulsed mid-byte -> all outputs at reset values; the next full frame with 8'h36 is received correctly.

Source files
------------

// File: rtl/pkg_ili9341.sv
// Shared types for the ILI9341-style SPI responder: FSM states and the
// received-byte record (data plus the D/C flag captured with it).
package pkg_ili9341;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } byte_rec_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with single-clk
// rise/fall pulses derived from one extra delay flop.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  // Preset to the idle bus level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      q_d   <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // which is what turns this into a shift chain rather than one wire.
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/ili_spi_responder.sv
// SPI mode-0 byte responder: oversamples sclk with the system clock, delivers
// received bytes with their D/C flag over a valid/ready port and returns
// i_tx_byte on MISO during each byte slot.
module ili_spi_responder
  import pkg_ili9341::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_cs,
  input  logic       i_dc,
  input  logic [7:0] i_tx_byte,
  input  logic       i_rd_ready,
  output logic       o_miso,
  output logic [7:0] o_byte,
  output logic       o_byte_dc,
  output logic       o_byte_valid,
  output logic       o_overrun,
  output logic       o_frame_active
);

  logic sclk_rise, sclk_fall, mosi_s, cs_s, cs_fall, dc_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(i_sclk), .q(), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(i_mosi), .q(mosi_s), .rise(), .fall());
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(i_cs), .q(cs_s), .rise(), .fall(cs_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
    .clk(clk), .rst(rst), .d(i_dc), .q(dc_s), .rise(), .fall());

  state_t    state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr;
  byte_rec_t captured, byte_q;
  logic start, deselect, shift_in, shift_out, deliver, overrun_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_s)                              state_d = IDLE;
        else if (sclk_rise && bit_cnt == 3'd7) state_d = DONE;
      end
      DONE:    state_d = cs_s ? IDLE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start       = (state_q == IDLE) && cs_fall;
    deselect    = (state_q != IDLE) && (state_d == IDLE);
    shift_in    = (state_q == SHIFT) && !cs_s && sclk_rise;
    shift_out   = (state_q == SHIFT) && !cs_s && sclk_fall;
    deliver     = (state_q == DONE) && (!o_byte_valid || i_rd_ready);
    overrun_hit = (state_q == DONE) && o_byte_valid && !i_rd_ready;
  end

  // Shift datapath; the tx register reloads at the wrap rise so the first fall
  // of the next byte only has to present its MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      captured <= '0;
      o_miso   <= IDLE_MISO;
    end else if (start) begin
      bit_cnt <= '0;
      tx_sr   <= i_tx_byte;
      o_miso  <= i_tx_byte[7];
    end else if (deselect) begin
      bit_cnt <= '0;
      o_miso  <= IDLE_MISO;
    end else begin
      if (shift_in) begin
        rx_sr   <= {rx_sr[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          captured <= '{dc: dc_s, data: {rx_sr[6:0], mosi_s}};
          tx_sr    <= i_tx_byte;
        end
      end
      if (shift_out) begin
        if (bit_cnt == 3'd0) begin
          o_miso <= tx_sr[7];
        end else begin
          tx_sr  <= {tx_sr[6:0], 1'b0};
          o_miso <= tx_sr[6];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q       <= '0;
      o_byte_valid <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (deliver) begin
        byte_q       <= captured;
        o_byte_valid <= 1'b1;
      end else if (o_byte_valid && i_rd_ready) begin
        o_byte_valid <= 1'b0;
      end
      if (overrun_hit) o_overrun <= 1'b1;
    end
  end

  assign o_byte         = byte_q.data;
  assign o_byte_dc      = byte_q.dc;
  assign o_frame_active = ~cs_s;

endmodule

// File: tb/tb_ili_spi_responder.sv
// Directed-plus-random bench for ili_spi_responder: an SPI master model drives
// bytes at sclk = clk/8 and a queue-based model predicts delivery and overrun.
module tb_ili_spi_responder;

  localparam int   SYNC_STAGES = 2;
  localparam logic IDLE_MISO   = 1'b1;

  logic       clk = 1'b0;
  logic       rst, sclk, mosi, cs, dc, rd_ready;
  logic [7:0] tx_byte;
  logic       miso, byte_dc, byte_valid, overrun, frame_active;
  logic [7:0] byte_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state: bytes expected on the valid/ready port, the byte held while
  // the consumer stalls, and the sticky overrun flag.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] m_hold;
  bit         m_hold_v;
  bit         m_ovr;

  always #5 clk = ~clk;

  ili_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .IDLE_MISO(IDLE_MISO)) dut (
    .clk(clk), .rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_cs(cs), .i_dc(dc),
    .i_tx_byte(tx_byte), .i_rd_ready(rd_ready), .o_miso(miso), .o_byte(byte_o),
    .o_byte_dc(byte_dc), .o_byte_valid(byte_valid), .o_overrun(overrun),
    .o_frame_active(frame_active));

  always @(negedge clk)
    if (!rst && byte_valid && rd_ready) got_q.push_back({byte_dc, byte_o});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [8:0] rec);
    if (rd_ready)       exp_q.push_back(rec);
    else if (!m_hold_v) begin m_hold = rec; m_hold_v = 1'b1; end
    else                m_ovr = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    rd_ready = v;
    if (v && m_hold_v) begin
      exp_q.push_back(m_hold);
      m_hold_v = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] d, input logic d_dc, input logic [7:0] next_tx,
                          input bit meas, output logic [7:0] mrx, output int lat);
    lat = -1;
    mrx = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = d[i];
      dc   = d_dc;
      if (i == 0) tx_byte = next_tx;
      repeat (4) @(negedge clk);
      mrx[i] = miso;
      sclk = 1'b1;
      if (meas && i == 0) begin
        lat = 0;
        while (!byte_valid && lat < 20) begin
          @(negedge clk);
          lat++;
        end
      end
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    model_byte({d_dc, d});
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin(input logic [7:0] tx);
    tx_byte = tx;
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    sclk = 1'b0; cs = 1'b1; mosi = 1'b0; dc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",   byte_valid,   0);
    check("rst_byte",    byte_o,       0);
    check("rst_dc",      byte_dc,      0);
    check("rst_overrun", overrun,      0);
    check("rst_frame",   frame_active, 0);
    check("rst_miso",    miso,         IDLE_MISO);
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    m_hold_v = 1'b0; m_ovr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] mrx, prev_tx, nt, d;
    logic       ddc;
    int         lat;

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0;
    rd_ready = 1'b0; tx_byte = 8'h00;
    apply_reset();

    // Single command byte, consumer stalled so the held byte can be inspected.
    frame_begin(8'h00);
    check("frame_active", frame_active, 1);
    spi_byte(8'h2A, 1'b0, 8'h00, 1'b1, mrx, lat);
    check("valid_latency", lat, SYNC_STAGES + 2);
    check("t1_byte",    byte_o,     m_hold[7:0]);
    check("t1_dc",      byte_dc,    m_hold[8]);
    check("t1_valid",   byte_valid, 1);
    check("t1_overrun", overrun,    m_ovr);
    frame_end();
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("t1_consumed", byte_valid, 0);
    compare_rx("t1");

    // Back-to-back bytes in one frame, MISO returning the presented tx bytes.
    frame_begin(8'hA5);
    nt = 8'($urandom);
    spi_byte(8'h2C, 1'b0, nt, 1'b0, mrx, lat);
    check("miso_a5", mrx, 8'hA5);
    prev_tx = nt;
    nt = 8'($urandom);
    spi_byte(8'hF8, 1'b1, nt, 1'b0, mrx, lat);
    check("miso_b2", mrx, prev_tx);
    prev_tx = nt;
    for (int k = 0; k < 6; k++) begin
      d   = 8'($urandom);
      ddc = 1'($urandom);
      nt  = 8'($urandom);
      spi_byte(d, ddc, nt, 1'b0, mrx, lat);
      check("miso_rand", mrx, prev_tx);
      prev_tx = nt;
    end
    frame_end();
    check("miso_idle", miso, IDLE_MISO);
    compare_rx("t2");

    // Partial byte aborted by deselect, then a clean byte.
    frame_begin(8'h00);
    spi_bits(8'hFF, 5);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_frame", frame_active, 0);
    frame_begin(8'h00);
    spi_byte(8'h11, 1'b1, 8'h00, 1'b0, mrx, lat);
    frame_end();
    compare_rx("t3");
    check("t3_overrun", overrun, m_ovr);

    // Stalled consumer: second byte overruns, first byte is kept.
    set_ready(1'b0);
    frame_begin(8'h00);
    spi_byte(8'h01, 1'b0, 8'h00, 1'b0, mrx, lat);
    spi_byte(8'h02, 1'b0, 8'h00, 1'b0, mrx, lat);
    frame_end();
    check("t4_byte",    byte_o,     m_hold[7:0]);
    check("t4_overrun", overrun,    m_ovr);
    check("t4_valid",   byte_valid, 1);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("t4_sticky", overrun,    m_ovr);
    check("t4_drain",  byte_valid, 0);
    compare_rx("t4");

    // Reset mid-byte, then a full frame.
    frame_begin(8'h00);
    spi_bits(8'hA0, 3);
    apply_reset();
    frame_begin(8'h00);
    spi_byte(8'h36, 1'b1, 8'h00, 1'b0, mrx, lat);
    frame_end();
    compare_rx("t5");
    check("t5_overrun", overrun, m_ovr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
